// File: rtl/parity_frame_checker.sv
// parity_frame_checker
//   Purpose : deserialises DATA_BITS data bits (LSB first) plus one parity bit,
//             checks even/odd parity, presents the word with a 1-cycle strobe and
//             keeps a saturating count of frames that failed the parity check.
//   Ports   : clk, reset (async, active-low), in_valid/in_bit (serial input),
//             sync (abort partial frame), data_out, frame_valid, parity_err,
//             err_count, busy.
//   Latency : outputs update at the edge that accepts the parity bit; frame_valid
//             is high for the following cycle only. No backpressure: every
//             in_valid bit is consumed.
module parity_frame_checker #(
  parameter int DATA_BITS  = 8,
  parameter int ODD_PARITY = 0,
  parameter int CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic                 in_bit,
  input  logic                 sync,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 frame_valid,
  output logic                 parity_err,
  output logic [CNT_W-1:0]     err_count,
  output logic                 busy
);

  localparam int             CW      = $clog2(DATA_BITS + 1);
  localparam logic           ODD_L   = (ODD_PARITY != 0);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 par_q, par_d;
  logic [DATA_BITS-1:0] asm_q, asm_d;
  logic [DATA_BITS-1:0] data_d;
  logic                 fv_d;
  logic                 perr_d;
  logic [CNT_W-1:0]     errc_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      par_q       <= 1'b0;
      asm_q       <= '0;
      data_out    <= '0;
      frame_valid <= 1'b0;
      parity_err  <= 1'b0;
      err_count   <= '0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      par_q       <= par_d;
      asm_q       <= asm_d;
      data_out    <= data_d;
      frame_valid <= fv_d;
      parity_err  <= perr_d;
      err_count   <= errc_d;
      // Registered decode of the next state, so busy tracks state != IDLE exactly.
      busy        <= (state_d != IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    asm_d   = asm_q;
    data_d  = data_out;
    fv_d    = 1'b0;
    perr_d  = parity_err;
    errc_d  = err_count;

    if (sync) begin
      // Abort wins over a coincident bit; completed-frame outputs are untouched.
      state_d = IDLE;
      cnt_d   = '0;
      par_d   = 1'b0;
    end else if (in_valid) begin
      case (state_q)
        IDLE: begin
          // Starting a fresh word also clears leftovers from the previous frame,
          // which lets DATA simply OR each new bit into place.
          asm_d   = DATA_BITS'(in_bit);
          par_d   = in_bit;
          cnt_d   = CW'(1);
          state_d = DATA;
        end
        DATA: begin
          asm_d = asm_q | (DATA_BITS'(in_bit) << cnt_q);
          par_d = par_q ^ in_bit;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(DATA_BITS - 1)) begin
            state_d = PARITY;
          end
        end
        PARITY: begin
          state_d = IDLE;
          cnt_d   = '0;
          par_d   = 1'b0;
          fv_d    = 1'b1;
          data_d  = asm_q;
          perr_d  = par_q ^ in_bit ^ ODD_L;
          if (perr_d && (err_count != CNT_MAX)) begin
            errc_d = err_count + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          par_d   = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parity_frame_checker.sv
// tb_parity_frame_checker
//   Drives three checker builds (even/8-bit count, odd/8-bit count, even/2-bit
//   count) from one shared serial stream and compares every output, every cycle,
//   against a frame-level reference model built from a queue of received bits.
module tb_parity_frame_checker;

  logic clk;
  logic reset;
  logic in_valid;
  logic in_bit;
  logic sync;

  logic [7:0] d0_data, d1_data, d2_data;
  logic       d0_fv, d1_fv, d2_fv;
  logic       d0_perr, d1_perr, d2_perr;
  logic [7:0] d0_cnt, d1_cnt;
  logic [1:0] d2_cnt;
  logic       d0_busy, d1_busy, d2_busy;

  parity_frame_checker #(.DATA_BITS(8), .ODD_PARITY(0), .CNT_W(8)) dut_even (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit), .sync(sync),
    .data_out(d0_data), .frame_valid(d0_fv), .parity_err(d0_perr),
    .err_count(d0_cnt), .busy(d0_busy)
  );

  parity_frame_checker #(.DATA_BITS(8), .ODD_PARITY(1), .CNT_W(8)) dut_odd (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit), .sync(sync),
    .data_out(d1_data), .frame_valid(d1_fv), .parity_err(d1_perr),
    .err_count(d1_cnt), .busy(d1_busy)
  );

  parity_frame_checker #(.DATA_BITS(8), .ODD_PARITY(0), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit), .sync(sync),
    .data_out(d2_data), .frame_valid(d2_fv), .parity_err(d2_perr),
    .err_count(d2_cnt), .busy(d2_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: frame-level view of the link.
  int          bits_q[$];
  int          exp_data;
  int          exp_fv;
  int          exp_err[3];
  int          exp_cnt[3];
  int          odd_sel[3] = '{0, 1, 0};
  int          cnt_max[3] = '{255, 255, 3};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    bits_q.delete();
    exp_data = 0;
    exp_fv   = 0;
    for (int k = 0; k < 3; k++) begin
      exp_err[k] = 0;
      exp_cnt[k] = 0;
    end
  endtask

  task automatic model_edge(input logic v, input logic b, input logic s);
    int ones;
    int word;
    exp_fv = 0;
    if (s) begin
      bits_q.delete();
    end else if (v) begin
      bits_q.push_back(int'(b));
      if (bits_q.size() == 9) begin
        word = 0;
        ones = 0;
        for (int i = 0; i < 9; i++) begin
          ones += bits_q[i];
          if (i < 8) word += bits_q[i] * (1 << i);
        end
        exp_data = word;
        exp_fv   = 1;
        for (int k = 0; k < 3; k++) begin
          exp_err[k] = ((ones % 2) != odd_sel[k]) ? 1 : 0;
          if (exp_err[k] == 1 && exp_cnt[k] < cnt_max[k]) exp_cnt[k]++;
        end
        bits_q.delete();
      end
    end
  endtask

  task automatic check_all();
    int eb;
    eb = (bits_q.size() != 0) ? 1 : 0;
    chk("even_data", 32'(d0_data), 32'(exp_data));
    chk("even_fv",   32'(d0_fv),   32'(exp_fv));
    chk("even_perr", 32'(d0_perr), 32'(exp_err[0]));
    chk("even_cnt",  32'(d0_cnt),  32'(exp_cnt[0]));
    chk("even_busy", 32'(d0_busy), 32'(eb));
    chk("odd_data",  32'(d1_data), 32'(exp_data));
    chk("odd_fv",    32'(d1_fv),   32'(exp_fv));
    chk("odd_perr",  32'(d1_perr), 32'(exp_err[1]));
    chk("odd_cnt",   32'(d1_cnt),  32'(exp_cnt[1]));
    chk("odd_busy",  32'(d1_busy), 32'(eb));
    chk("sat_data",  32'(d2_data), 32'(exp_data));
    chk("sat_fv",    32'(d2_fv),   32'(exp_fv));
    chk("sat_perr",  32'(d2_perr), 32'(exp_err[2]));
    chk("sat_cnt",   32'(d2_cnt),  32'(exp_cnt[2]));
    chk("sat_busy",  32'(d2_busy), 32'(eb));
  endtask

  // Apply inputs for one clock, then check 1 time unit after the edge.
  task automatic step(input logic v, input logic b, input logic s);
    in_valid = v;
    in_bit   = b;
    sync     = s;
    @(posedge clk);
    model_edge(v, b, s);
    #1;
    check_all();
  endtask

  // Called at posedge+1: assert reset mid-cycle, check, release before next edge.
  task automatic async_reset();
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_all();
    #1 reset = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] word, input logic pbit,
                            input int gap_after, input int gap_len);
    logic [8:0] fr;
    fr = {pbit, word};
    for (int i = 0; i < 9; i++) begin
      step(1'b1, fr[i], 1'b0);
      if (i == gap_after) begin
        for (int g = 0; g < gap_len; g++) step(1'b0, 1'($urandom), 1'b0);
      end
    end
  endtask

  initial begin
    logic [7:0] w;
    reset    = 1'b0;
    in_valid = 1'b0;
    in_bit   = 1'b0;
    sync     = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1 reset = 1'b1;

    // 1: clean 0xA5 frame, contiguous bits
    step(1'b0, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b0, -1, 0);
    chk("t1_data", 32'(d0_data), 32'h0000_00A5);
    chk("t1_fv",   32'(d0_fv),   32'h1);
    chk("t1_perr", 32'(d0_perr), 32'h0);
    step(1'b0, 1'b0, 1'b0);
    chk("t1_fv_drop", 32'(d0_fv), 32'h0);

    // 2: 0x01 with parity 0 and a 3-cycle gap between bits 3 and 4
    send_frame(8'h01, 1'b0, 3, 3);
    chk("t2_data", 32'(d0_data), 32'h0000_0001);
    chk("t2_perr", 32'(d0_perr), 32'h1);
    chk("t2_cnt",  32'(d0_cnt),  32'h1);

    // 3: odd-parity build, 0x03 with parity 1 then 0
    send_frame(8'h03, 1'b1, -1, 0);
    chk("t3_odd_ok", 32'(d1_perr), 32'h0);
    send_frame(8'h03, 1'b0, -1, 0);
    chk("t3_odd_bad", 32'(d1_perr), 32'h1);

    // 4: partial frame aborted by sync with a coincident valid bit
    for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom), 1'b0);
    step(1'b1, 1'b1, 1'b1);
    send_frame(8'h3C, 1'b0, -1, 0);
    chk("t4_data", 32'(d0_data), 32'h0000_003C);
    chk("t4_perr", 32'(d0_perr), 32'h0);

    // sync coinciding with the parity bit must not complete the frame
    for (int i = 0; i < 8; i++) step(1'b1, 1'($urandom), 1'b0);
    step(1'b1, 1'b0, 1'b1);
    chk("sync_par_fv", 32'(d0_fv), 32'h0);

    // 5: async reset during bit 4, then a clean 0xFF frame
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
    in_valid = 1'b1;
    in_bit   = 1'b1;
    async_reset();
    chk("t5_rst_data", 32'(d0_data), 32'h0);
    chk("t5_rst_busy", 32'(d0_busy), 32'h0);
    send_frame(8'hFF, 1'b0, -1, 0);
    chk("t5_data", 32'(d0_data), 32'h0000_00FF);
    chk("t5_perr", 32'(d0_perr), 32'h0);

    // 6: five back-to-back bad frames into the 2-bit counter
    step(1'b0, 1'b0, 1'b0);
    async_reset();
    for (int f = 0; f < 5; f++) begin
      send_frame(8'h01, 1'b0, -1, 0);
      chk("t6_fv", 32'(d2_fv), 32'h1);
      chk("t6_cnt", 32'(d2_cnt), (f < 3) ? 32'(f + 1) : 32'h3);
    end

    // Random traffic: gaps, occasional sync and rare async resets
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 599) == 0) begin
        async_reset();
      end
      w = 8'($urandom);
      step(($urandom_range(0, 3) != 0), w[0], ($urandom_range(0, 60) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
